// File: rtl/mux_signals.sv
// Shared mux-select and fetch-state types used across the front end.
package mux_signals;

    typedef enum logic [1:0] {
        PC_BRANCH = 2'd0,
        PC_JRA    = 2'd1,
        PC_JUMP   = 2'd2,
        PC_NPC    = 2'd3
    } pc_ms;

    typedef enum logic [1:0] {
        FETCH  = 2'd0,
        HOLD   = 2'd1,
        HALTED = 2'd2
    } fetch_state_t;

    localparam int unsigned WORD_W = 32;

    // Sequential PC increment; wraps naturally at the top of the address space.
    function automatic logic [WORD_W-1:0] pc_plus4(input logic [WORD_W-1:0] pc);
        return pc + 32'd4;
    endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Fetch-unit bundle: redirect/stall/halt control, instruction memory and decode latch.
// The misalign flag exists only when PC_ALIGN_CHECK_EN is defined.
interface fetch_unit_if;
    import mux_signals::*;

    logic        redir;
    pc_ms        pc_sel;
    logic [31:0] branch_addr;
    logic [31:0] jra;
    logic [25:0] jaddr;
    logic        stall;
    logic        halt;
    logic        imem_ren;
    logic [31:0] imem_addr;
    logic        ihit;
    logic [31:0] imem_load;
    logic [31:0] instr;
    logic [31:0] npc_out;
    logic        instr_valid;
    logic        halted;
`ifdef PC_ALIGN_CHECK_EN
    logic        misalign;
`endif

    modport master (
        input  redir, pc_sel, branch_addr, jra, jaddr, stall, halt, ihit, imem_load,
`ifdef PC_ALIGN_CHECK_EN
        output misalign,
`endif
        output imem_ren, imem_addr, instr, npc_out, instr_valid, halted
    );

    modport slave (
        output redir, pc_sel, branch_addr, jra, jaddr, stall, halt, ihit, imem_load,
`ifdef PC_ALIGN_CHECK_EN
        input  misalign,
`endif
        input  imem_ren, imem_addr, instr, npc_out, instr_valid, halted
    );

endinterface

// File: rtl/pc_target_mux.sv
// Combinational redirect-target selection. Without ALIGN_CHECK the low two
// target bits are cleared; with it they pass through and flag misalignment.
module pc_target_mux
    import mux_signals::*;
#(
    parameter bit ALIGN_CHECK = 1'b0
) (
    input  pc_ms        pc_sel,
    input  logic [31:0] pc,
    input  logic [31:0] branch_addr,
    input  logic [31:0] jra,
    input  logic [25:0] jaddr,
    output logic [31:0] target,
    output logic        misaligned
);

    logic [31:0] target_raw;

    always_comb begin
        target_raw = pc_plus4(pc);
        unique case (pc_sel)
            PC_BRANCH: target_raw = branch_addr;
            PC_JRA:    target_raw = jra;
            PC_JUMP:   target_raw = {pc[31:28], jaddr, 2'b00};
            default:   target_raw = pc_plus4(pc);
        endcase
    end

    always_comb begin
        if (ALIGN_CHECK) begin
            target     = target_raw;
            misaligned = |target_raw[1:0];
        end else begin
            target     = {target_raw[31:2], 2'b00};
            misaligned = 1'b0;
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: PC register, FETCH/HOLD/HALTED control and the fetch/decode latch.
// Optional PC_ALIGN_CHECK_EN adds a sticky misalign flag that halts on unaligned redirects.
module fetch_unit
    import mux_signals::*;
#(
    parameter logic [31:0] PC_INIT = 32'h00000000
) (
    input  logic         CLK,
    input  logic         nRST,
    fetch_unit_if.master bus
);

`ifdef PC_ALIGN_CHECK_EN
    localparam bit ALIGN_CHECK = 1'b1;
`else
    localparam bit ALIGN_CHECK = 1'b0;
`endif

    fetch_state_t state, next_state;
    logic [31:0]  pc;
    logic [31:0]  pc_next;
    logic [31:0]  target;
    logic         misaligned;
    logic         redir_eff;
    logic [31:0]  hold_instr_p0, hold_npc_p0;
    logic [31:0]  instr_p1, npc_p1;
    logic         vld_p1;

    pc_target_mux #(.ALIGN_CHECK(ALIGN_CHECK)) u_target (
        .pc_sel      (bus.pc_sel),
        .pc          (pc),
        .branch_addr (bus.branch_addr),
        .jra         (bus.jra),
        .jaddr       (bus.jaddr),
        .target      (target),
        .misaligned  (misaligned)
    );

    assign pc_next   = pc_plus4(pc);
    assign redir_eff = bus.redir && (bus.pc_sel != PC_NPC);

    always_ff @(posedge CLK) begin
        if (!nRST) state <= FETCH;
        else       state <= next_state;
    end

    // Halt beats redirect, redirect beats stall.
    always_comb begin
        next_state = state;
        if (bus.halt) begin
            next_state = HALTED;
        end else begin
            unique case (state)
                FETCH: begin
                    if (redir_eff)                next_state = misaligned ? HALTED : FETCH;
                    else if (bus.ihit && bus.stall) next_state = HOLD;
                end
                HOLD: begin
                    if (redir_eff)       next_state = misaligned ? HALTED : FETCH;
                    else if (!bus.stall) next_state = FETCH;
                end
                default: next_state = HALTED;
            endcase
        end
    end

    always_comb begin
        bus.imem_ren = (state == FETCH);
        bus.halted   = (state == HALTED);
    end

    // Stage p0: PC and hold buffer; stage p1: fetch/decode latch.
    always_ff @(posedge CLK) begin
        if (!nRST) begin
            pc            <= PC_INIT;
            hold_instr_p0 <= '0;
            hold_npc_p0   <= '0;
            instr_p1      <= '0;
            npc_p1        <= '0;
            vld_p1        <= 1'b0;
        end else if (bus.halt) begin
            vld_p1 <= 1'b0;
        end else if (redir_eff && state != HALTED) begin
            vld_p1 <= 1'b0;
            if (!misaligned) pc <= target;
        end else begin
            unique case (state)
                FETCH: begin
                    if (bus.ihit) begin
                        pc <= pc_next;
                        if (bus.stall) begin
                            hold_instr_p0 <= bus.imem_load;
                            hold_npc_p0   <= pc_next;
                        end else begin
                            instr_p1 <= bus.imem_load;
                            npc_p1   <= pc_next;
                            vld_p1   <= 1'b1;
                        end
                    end else if (!bus.stall) begin
                        vld_p1 <= 1'b0;
                    end
                end
                HOLD: begin
                    if (!bus.stall) begin
                        instr_p1 <= hold_instr_p0;
                        npc_p1   <= hold_npc_p0;
                        vld_p1   <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef PC_ALIGN_CHECK_EN
    logic misalign_q;

    always_ff @(posedge CLK) begin
        if (!nRST)
            misalign_q <= 1'b0;
        else if (!bus.halt && state != HALTED && redir_eff && misaligned)
            misalign_q <= 1'b1;
    end

    assign bus.misalign = misalign_q;
`endif

    assign bus.imem_addr   = pc;
    assign bus.instr       = instr_p1;
    assign bus.npc_out     = npc_p1;
    assign bus.instr_valid = vld_p1;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed and randomized bench for fetch_unit against a queue-based reference model.
module tb_fetch_unit;
    import mux_signals::*;

    localparam logic [31:0] PC_INIT = 32'h00000000;

    logic CLK  = 1'b0;
    logic nRST = 1'b0;

    fetch_unit_if fif();

    fetch_unit #(.PC_INIT(PC_INIT)) dut (
        .CLK  (CLK),
        .nRST (nRST),
        .bus  (fif)
    );

    always #5 CLK = ~CLK;

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] npc;
    } held_t;

    logic [31:0] m_pc, m_instr, m_npc;
    logic        m_valid, m_halted, m_mis, m_known;
    held_t       held[$];

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], ~a[15:0]} ^ 32'h12345678;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic set_in(input bit ihit, input bit stall, input bit redir, input pc_ms sel,
                          input logic [31:0] ba, input logic [31:0] jr,
                          input logic [25:0] ja, input bit halt);
        fif.ihit        = ihit;
        fif.stall       = stall;
        fif.redir       = redir;
        fif.pc_sel      = sel;
        fif.branch_addr = ba;
        fif.jra         = jr;
        fif.jaddr       = ja;
        fif.halt        = halt;
    endtask

    task automatic model_step();
        logic [31:0] t;
        if (!nRST) begin
            m_pc = PC_INIT; m_instr = '0; m_npc = '0; m_valid = 1'b0;
            m_halted = 1'b0; m_mis = 1'b0; m_known = 1'b1;
            held.delete();
        end else if (m_halted) begin
            // frozen until reset
        end else if (fif.halt) begin
            m_halted = 1'b1;
            m_valid  = 1'b0;
        end else if (fif.redir && fif.pc_sel != PC_NPC) begin
            case (fif.pc_sel)
                PC_BRANCH: t = fif.branch_addr;
                PC_JRA:    t = fif.jra;
                default:   t = {m_pc[31:28], fif.jaddr, 2'b00};
            endcase
            m_valid = 1'b0;
`ifdef PC_ALIGN_CHECK_EN
            if (t[1:0] != 2'b00) begin
                m_mis    = 1'b1;
                m_halted = 1'b1;
            end else begin
                m_pc = t;
                held.delete();
            end
`else
            m_pc = {t[31:2], 2'b00};
            held.delete();
`endif
        end else if (held.size() != 0) begin
            if (!fif.stall) begin
                m_instr = held[0].instr;
                m_npc   = held[0].npc;
                m_valid = 1'b1;
                held.delete();
            end
        end else if (fif.ihit) begin
            if (!fif.stall) begin
                m_instr = fif.imem_load;
                m_npc   = m_pc + 32'd4;
                m_valid = 1'b1;
            end else begin
                held.push_back('{instr: fif.imem_load, npc: m_pc + 32'd4});
            end
            m_pc = m_pc + 32'd4;
        end else if (!fif.stall) begin
            m_valid = 1'b0;
        end
    endtask

    task automatic tick();
        fif.imem_load = mem_word(m_pc);
        #1;
        if (m_known) begin
            check("imem_addr", fif.imem_addr, m_pc);
            check("imem_ren", {31'd0, fif.imem_ren}, {31'd0, !m_halted && held.size() == 0});
            check("halted", {31'd0, fif.halted}, {31'd0, m_halted});
        end
        @(posedge CLK);
        model_step();
        #1;
        check("instr", fif.instr, m_instr);
        check("npc_out", fif.npc_out, m_npc);
        check("instr_valid", {31'd0, fif.instr_valid}, {31'd0, m_valid});
`ifdef PC_ALIGN_CHECK_EN
        check("misalign", {31'd0, fif.misalign}, {31'd0, m_mis});
`endif
    endtask

    task automatic idle();
        set_in(1'b0, 1'b0, 1'b0, PC_NPC, '0, '0, '0, 1'b0);
    endtask

    initial begin
        m_pc = PC_INIT; m_instr = '0; m_npc = '0;
        m_valid = 1'b0; m_halted = 1'b0; m_mis = 1'b0; m_known = 1'b0;
        fif.imem_load = '0;
        idle();

        // Reset, then a straight run of hits from PC_INIT
        nRST = 1'b0;
        tick(); tick();
        check("rst_addr", fif.imem_addr, PC_INIT);
        nRST = 1'b1;
        set_in(1'b1, 1'b0, 1'b0, PC_NPC, '0, '0, '0, 1'b0);
        for (int i = 0; i < 5; i++) tick();
        check("seq_addr", fif.imem_addr, 32'h14);
        check("seq_npc", fif.npc_out, 32'h14);

        // Stall on a hit at 0x40, release three cycles later
        set_in(1'b0, 1'b0, 1'b1, PC_JRA, '0, 32'h40, '0, 1'b0);
        tick();
        set_in(1'b1, 1'b1, 1'b0, PC_NPC, '0, '0, '0, 1'b0);
        tick(); tick(); tick();
        set_in(1'b1, 1'b0, 1'b0, PC_NPC, '0, '0, '0, 1'b0);
        tick();
        check("hold_instr", fif.instr, mem_word(32'h40));
        check("hold_npc", fif.npc_out, 32'h44);
        check("hold_next_addr", fif.imem_addr, 32'h44);

        // Jump redirect with a same-cycle hit
        set_in(1'b0, 1'b0, 1'b1, PC_JRA, '0, 32'h80000010, '0, 1'b0);
        tick();
        set_in(1'b1, 1'b1, 1'b1, PC_JUMP, '0, '0, 26'h10, 1'b0);
        tick();
        check("jump_addr", fif.imem_addr, 32'h80000040);
        check("jump_valid", {31'd0, fif.instr_valid}, 32'd0);

        // PC_NPC redirect ignored, then a register jump
        set_in(1'b1, 1'b0, 1'b1, PC_NPC, '0, 32'h1000, '0, 1'b0);
        tick();
        check("npc_redir_addr", fif.imem_addr, 32'h80000044);
        set_in(1'b0, 1'b0, 1'b1, PC_JRA, '0, 32'h1000, '0, 1'b0);
        tick();
        check("jra_addr", fif.imem_addr, 32'h1000);

        // Unaligned branch target
        set_in(1'b0, 1'b0, 1'b1, PC_BRANCH, 32'h102, '0, '0, 1'b0);
        tick();
`ifdef PC_ALIGN_CHECK_EN
        check("mis_flag", {31'd0, fif.misalign}, 32'd1);
        check("mis_halted", {31'd0, fif.halted}, 32'd1);
`else
        check("branch_align", fif.imem_addr, 32'h100);
`endif
        idle();
        nRST = 1'b0; tick(); nRST = 1'b1;

        // Halt together with redirect, then reset restart
        set_in(1'b1, 1'b0, 1'b1, PC_JRA, '0, 32'h2000, '0, 1'b1);
        tick();
        set_in(1'b1, 1'b0, 1'b1, PC_JRA, '0, 32'h3000, '0, 1'b0);
        for (int i = 0; i < 4; i++) tick();
        check("halt_flag", {31'd0, fif.halted}, 32'd1);
        check("halt_ren", {31'd0, fif.imem_ren}, 32'd0);
        nRST = 1'b0;
        tick();
        nRST = 1'b1;
        idle();
        tick();
        check("restart_addr", fif.imem_addr, PC_INIT);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            logic [31:0] ba, jr;
            ba = $urandom();
            jr = $urandom();
            if ($urandom_range(0, 7) != 0) ba[1:0] = 2'b00;
            if ($urandom_range(0, 7) != 0) jr[1:0] = 2'b00;
            nRST = ($urandom_range(0, 49) != 0);
            set_in($urandom_range(0, 2) != 0, $urandom_range(0, 2) == 0,
                   $urandom_range(0, 5) == 0, pc_ms'($urandom_range(0, 3)),
                   ba, jr, 26'($urandom()), $urandom_range(0, 79) == 0);
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
